rotate_sequencer: RTL
=====================

Name: rotate_sequencer

Overview:
Iterative rotate controller for a WIDTH-bit word. It accepts a rotate request (data, amount, direction) over a valid/ready handshake. It sequences a single-step rotator that moves 0..3 positions per cycle (2-bit step shamt) until the full amount is applied. It then presents the result on a valid/ready output. It sits between a requester (CPU/ALU shifter front-end) and the small step rotator, which it shares over multiple cycles.

Parameters:
WIDTH, 16, data word width; must be a power of two, minimum 4.
AMT_W, $clog2(WIDTH), width of the rotate amount (0..WIDTH-1).
STEP_MAX, 3, maximum positions per step; fixed by the 2-bit step shamt.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  request present.
in_ready  output  1  controller can accept a request.
in_data  input  WIDTH  word to rotate.
in_amt  input  AMT_W  total rotate amount.
in_left  input  1  1 = rotate left, 0 = rotate right.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_data  output  WIDTH  rotated word.
busy  output  1  high in BUSY or DONE.

Behaviour:
- Single clock. Asynchronous active-low reset: reset_n=0 immediately forces the following, regardless of clk:
  - state=IDLE
  - data register=0, remaining=0, direction=0
  - out_valid=0, out_data=0, busy=0, in_ready=1
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at edge T, register in_data, in_amt and in_left.
  - If in_amt==0, go to DONE; otherwise go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: step=min(remaining,3); data <= rotate(data, step, dir); remaining <= remaining-step.
  - Go to DONE when remaining-step==0.
- DONE:
  - out_valid=1, out_data=data register, held stable until handshake.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready=0 in DONE; there is no overlap of an accepted request with a pending result.
- Latency: out_valid rises at T+1 for amt=0, else at T+1+ceil(amt/3).
  - Example: amt=15 gives 5 steps, valid at T+6.
- Rotation is modulo WIDTH with no bit loss. Left rotate moves bit i to bit (i+s) mod WIDTH; right rotate moves bit i to bit (i-s) mod WIDTH.
- in_valid while in_ready=0 is ignored. The requester must hold the request; nothing is queued.
- in_data, in_amt and in_left changing after acceptance have no effect.
- out_ready asserted outside DONE has no effect.
- Reset asserted mid-BUSY or mid-DONE discards the pending operation; no partial result is emitted. The first request after reset_n deassertion behaves normally.
- X on in_* while in_valid=0 must not propagate to state.

Decomposition:
- Package rot_pkg contains:
  - state_t enum {IDLE, BUSY, DONE}
  - constant STEP_MAX=3
  - constant STEP_W=2
- Sub-module rotate_step is combinational. Parameter WIDTH; inputs data[WIDTH], shamt[1:0], left; output rotated[WIDTH]. It is the only datapath instance.
- The controller holds the FSM, the data, remaining and direction registers, and the step-size computation.

Test Plan:
1. Reset: hold reset_n=0 -> out_valid=0, busy=0, in_ready=1, out_data=16'h0000; release -> still idle with the same values.
2. in_data=16'h8001, amt=1, left -> out_valid at T+2, out_data=16'h0003; with out_ready=1 -> IDLE, in_ready=1 next cycle.
3. in_data=16'h1234, amt=4, right -> steps 3 then 1, out_valid at T+3, out_data=16'h4123.
4. in_data=16'hA5C3, amt=0 -> out_valid at T+1, out_data=16'hA5C3.
5. in_data=16'h0001, amt=15, left -> out_valid at T+6, out_data=16'h8000. Then hold out_ready=0 for 3 cycles -> out_data stable. A second in_valid during BUSY/DONE is not accepted (in_ready=0).
6. Start amt=15 request; pulse reset_n low at T+3 between edges -> outputs clear asynchronously, no out_valid. Then request 16'h00F0, amt=4, left -> 16'h0F00 at T'+3.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared types and constants for the iterative rotate controller.
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned STEP_MAX = 3;
    localparam int unsigned STEP_W   = 2;

endpackage

// File: rtl/rotate_step.sv
// Combinational single-step rotator, 0..3 positions per pass.
module rotate_step
    import rot_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  data,
    input  logic [STEP_W-1:0] shamt,
    input  logic              left,
    output logic [WIDTH-1:0]  rotated
);

    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;

    // Doubling the word turns a rotate into a plain shift plus a slice.
    always_comb begin
        dbl_l   = {data, data} << shamt;
        dbl_r   = {data, data} >> shamt;
        rotated = left ? dbl_l[2*WIDTH-1:WIDTH] : dbl_r[WIDTH-1:0];
    end

endmodule

// File: rtl/rotate_sequencer.sv
// Rotate controller sequencing a shared step rotator over several cycles.
module rotate_sequencer
    import rot_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_left,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] step;
    logic [AMT_W-1:0]  rem_after;
    logic [WIDTH-1:0]  stepped;

    rotate_step #(.WIDTH(WIDTH)) u_step (
        .data    (data_q),
        .shamt   (step),
        .left    (dir_q),
        .rotated (stepped)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        step      = (rem_q > AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX)
                                               : rem_q[STEP_W-1:0];
        rem_after = rem_q - AMT_W'(step);
        state_d   = state_q;
        data_d    = data_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                // Inputs are only sampled on a handshake, so X while idle is harmless.
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_amt;
                    dir_d   = in_left;
                    state_d = (in_amt == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                busy   = 1'b1;
                data_d = stepped;
                rem_d  = rem_after;
                if (rem_after == '0) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = data_q;

endmodule
